// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants, segment table and FSM states for the serial 7-seg scanner
package seven_seg_pkg;
  localparam int FRAME_W = 16;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_CODE [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  typedef enum logic [2:0] {ST_IDLE, ST_CONVERT, ST_LOAD, ST_SHIFT, ST_LATCH} state_t;
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] r;
    r = SEG_BLANK;
    for (int i = 0; i < 10; i++) if (d == 4'(i)) r = SEG_CODE[i];
    return r;
  endfunction
  // decimal digits needed for the largest value a w-bit binary can hold
  function automatic int dec_digits(input int w);
    longint unsigned m;
    int d;
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    d = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: iterative double-dabble, one bin bit per cycle after start, with range flag
module bcd_dabble_seq #(
  parameter int BIN_W = 17,
  parameter int N_BCD = 6,
  parameter int N_DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               done,
  output logic [4*N_BCD-1:0] bcd,
  output logic               overflow
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = 64'd10 ** N_DIGITS;
  logic [BIN_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic [4*N_BCD-1:0] adj;
  assign done = cnt == CW'(1);
  always_comb begin
    adj = bcd;
    for (int i = 0; i < N_BCD; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      bcd <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      sr <= bin;
      cnt <= CW'(BIN_W);
      bcd <= '0;
      overflow <= 64'(bin) >= LIMIT;
    end else if (cnt != '0) begin
      {bcd, sr} <= {adj, sr} << 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/seven_seg_scan_serializer.sv
// seven_seg_scan_serializer: BCD-converts a snapshot per scan and shifts one 16-bit frame per digit
module seven_seg_scan_serializer
  import seven_seg_pkg::*;
#(
  parameter int BIN_W = 17,
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic                seg_data,
  output logic                seg_clk,
  output logic                seg_latch,
  output logic                overflow,
  output logic                busy_conv
);
  localparam int NB = dec_digits(BIN_W) > N_DIGITS ? dec_digits(BIN_W) : N_DIGITS;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int DIG_W = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("N_DIGITS must be in 1..8");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end
  state_t state, next;
  logic [FRAME_W-1:0] sr, frame;
  logic [3:0] bit_cnt, nib;
  logic [DIV_W-1:0] div_cnt;
  logic ph, blz_s, z;
  logic [DIG_W-1:0] dig;
  logic [N_DIGITS-1:0] dp_s, hi_zero;
  logic [4*NB-1:0] bcd;
  logic [7:0] seg;
  logic conv_start, conv_done, conv_ovf, last_dig, phase_end, frame_end;
  assign last_dig = dig == DIG_W'(N_DIGITS - 1);
  assign phase_end = div_cnt == DIV_W'(CLK_DIV - 1);
  assign frame_end = ph && phase_end && bit_cnt == 4'd15;
  assign conv_start = state == ST_IDLE || (state == ST_LATCH && last_dig);
  bcd_dabble_seq #(.BIN_W(BIN_W), .N_BCD(NB), .N_DIGITS(N_DIGITS)) u_bcd (
    .clk(clk), .rst(rst), .start(conv_start), .bin(bin),
    .done(conv_done), .bcd(bcd), .overflow(conv_ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:    next = ST_CONVERT;
      ST_CONVERT: next = conv_done ? ST_LOAD : ST_CONVERT;
      ST_LOAD:    next = ST_SHIFT;
      ST_SHIFT:   next = frame_end ? ST_LATCH : ST_SHIFT;
      ST_LATCH:   next = last_dig ? ST_CONVERT : ST_LOAD;
      default:    next = ST_IDLE;
    endcase
  end
  // dp goes on after blanking so a blanked digit can still show its point; inversion is last
  always_comb begin
    hi_zero = '0;
    z = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      z = z && bcd[4*i +: 4] == 4'd0;
      hi_zero[i] = z;
    end
    nib = bcd[4*dig +: 4];
    seg = overflow ? SEG_DASH : (blz_s && dig != '0 && hi_zero[dig]) ? SEG_BLANK : seg_of(nib);
    seg[7] = seg[7] | dp_s[dig];
    seg = SEG_ACTIVE_LOW ? ~seg : seg;
    frame = {seg, 8'(8'd1 << dig)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ph <= 1'b0;
      dig <= '0;
      dp_s <= '0;
      blz_s <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (conv_start) begin
        dp_s <= dp_mask;
        blz_s <= blank_lz;
      end
      if (state == ST_CONVERT && conv_done) overflow <= conv_ovf;
      if (state == ST_LOAD) begin
        sr <= frame;
        bit_cnt <= '0;
        div_cnt <= '0;
        ph <= 1'b0;
      end else if (state == ST_SHIFT) begin
        div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
        if (phase_end) begin
          ph <= !ph;
          if (ph) begin
            sr <= sr << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
      if (state == ST_LATCH) dig <= last_dig ? '0 : dig + 1'b1;
    end
  end
  assign seg_data = state == ST_SHIFT && sr[FRAME_W-1];
  assign seg_clk = state == ST_SHIFT && ph;
  assign seg_latch = state == ST_LATCH;
  assign busy_conv = state == ST_CONVERT;
endmodule
